fp_add_normalize: RTL and testbench
===================================

Name: fp_add_normalize

Overview:
- Back end of the FP add/subtract path. Consumes the aligned-operand bundle produced by FP execute stage 2: larger-exponent significand, aligned smaller significand, guard/round/sticky, exponent, sign and logical-subtract flag.
- Performs the significand add or subtract, leading-zero count, normalization shift, round-to-nearest-even and IEEE-754 single packing.
- Two-stage, fully pipelined, per-lane datapath with valid tracking and rollback squash. Feeds the FP writeback mux.

Parameters:
- NUM_LANES, 16, number of vector lanes (matches NUM_VECTOR_LANES).
- THREAD_IDX_W, 2, width of the local thread index.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous, active-low reset
- wb_rollback_en  in  1  rollback request
- wb_rollback_thread_idx  in  THREAD_IDX_W  thread being rolled back
- wb_rollback_pipeline  in  pipeline_sel_t  pipeline that raised the rollback
- in_valid  in  1  input bundle valid
- in_thread_idx  in  THREAD_IDX_W  thread of the input bundle
- in_mask  in  NUM_LANES  lane mask
- in_significand_le  in  NUM_LANES x 32  larger significand; bits 23:0 used, hidden bit at 23
- in_significand_se  in  NUM_LANES x 32  aligned smaller significand; bits 23:0 used
- in_guard, in_round, in_sticky  in  NUM_LANES each  alignment shift-out bits
- in_logical_subtract  in  NUM_LANES  1 = subtract magnitudes
- in_exponent  in  NUM_LANES x 8  biased exponent of the larger operand
- in_sign  in  NUM_LANES  result sign
- in_result_inf, in_result_nan  in  NUM_LANES each  special-case overrides
- out_valid  out  1  result valid
- out_thread_idx  out  THREAD_IDX_W  thread of the result
- out_mask  out  NUM_LANES  lane mask
- out_result  out  NUM_LANES x 32  packed IEEE single results

Behaviour:
- Latency and throughput
  - Bundle accepted in cycle N appears on outputs in cycle N+2.
  - One bundle per cycle; no stall, no backpressure.
- Reset
  - reset_n low asynchronously clears both stage valids, out_valid, out_thread_idx, out_mask and out_result to 0.
  - A bundle in flight when reset asserts is dropped.
- Squash rule
  - A stage's input is squashed (valid not propagated) when wb_rollback_en && rollback_thread_idx == that stage's thread && wb_rollback_pipeline == PIPE_MEM.
  - Evaluated independently at stage A input (in_*) and stage B input (A-register thread).
  - Data registers load regardless of valid.
- Stage A
  - op_l = {1'b0, le[23:0], 3'b000}
  - op_s = {1'b0, se[23:0], g, r, s}
  - raw[27:0] = subtract ? op_l - op_s : op_l + op_s
  - lzc = leading-zero count of raw (28 when raw == 0).
  - Register raw, lzc, exponent, sign, inf, nan, mask, thread.
- Stage B: normalization
  - raw[27] set: shift right 1, sticky keeps the dropped bit, exp + 1.
  - Otherwise: shift left (lzc-1) so the hidden bit lands on bit 26, exp - (lzc-1), computed as a signed 10-bit value.
- Stage B: rounding (RNE)
  - mant = n[26:3], G = n[2], S' = |n[1:0].
  - Increment when G && (S' || mant[0]).
  - Rounding carry out of bit 23 gives exp + 1, mant = 0x800000.
- Stage B: output selection, in priority order
  1. nan: 0x7FFFFFFF
  2. inf: {sign, 8'hFF, 23'd0}
  3. raw == 0: 0x00000000 (+0)
  4. exp >= 255: {sign, 8'hFF, 23'd0}
  5. exp <= 0: {sign, 31'd0} (flush to zero)
  6. otherwise: {sign, exp[7:0], mant[22:0]}
- Lane independence
  - Lanes with mask = 0 are still computed; the mask is passed through unchanged.

Optional Feature:
- Macro: FP_DENORMAL_EN
- Defined: when exp <= 0 and raw != 0, the significand is shifted right (1 - exp) further before rounding, with the shifted-out bits ORed into sticky. The result packs with exponent field 0. Rounding carry into bit 23 yields exponent field 1.
- Undefined: flush to signed zero as specified in Behaviour.

Test Plan:
- 1.0 + 1.0 (le = se = 0x800000, exp 127, add, g/r/s = 0) -> out_result 0x40000000 in cycle N+2, out_valid 1 for one cycle.
- 1.0 - 1.0 (subtract, same operands) -> 0x00000000. 1.0 - 0.75 (se = 0x600000) -> 0x3E800000.
- Ties and overflow:
  - le = 0x800000, se = 0, g = 1, r = s = 0 -> 0x3F800000 (tie to even).
  - le = 0x800001, same g/r/s -> 0x3F800002.
  - exp 254, le = se = 0xC00000, add -> 0x7F800000.
- Rollback: in_valid with thread 2 and a same-cycle rollback for thread 2 from PIPE_MEM -> no out_valid. Rollback for thread 1 or from a non-MEM pipeline -> result delivered. Rollback hitting stage B in cycle N+1 -> dropped.
- Special cases and reset:
  - in_result_nan = 1 -> 0x7FFFFFFF regardless of operands.
  - reset_n low in cycle N+1 with a bundle in flight -> out_valid stays 0 and out_result reads 0.
- Underflow: exp 1, le = 0x800000, se = 0x400000, subtract -> 0x00400000 with FP_DENORMAL_EN defined, 0x00000000 without.

Source files
------------

// File: rtl/fp_add_normalize.sv
// fp_add_normalize: back end of the FP add/subtract path.
// Stage A adds or subtracts the aligned significands and counts leading zeros.
// Stage B normalizes, rounds to nearest even, and packs IEEE-754 singles.
// Optional macro FP_DENORMAL_EN: produce subnormal results instead of
// flushing underflowed results to signed zero.

package fp_add_normalize_pkg;
  typedef enum logic [1:0] {
    PIPE_MEM       = 2'd0,
    PIPE_INT_ARITH = 2'd1,
    PIPE_FP_ARITH  = 2'd2,
    PIPE_SFU       = 2'd3
  } pipeline_sel_t;
endpackage

module fp_add_normalize
  import fp_add_normalize_pkg::*;
#(
  parameter int NUM_LANES    = 16,
  parameter int THREAD_IDX_W = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          wb_rollback_en,
  input  logic [THREAD_IDX_W-1:0]       wb_rollback_thread_idx,
  input  pipeline_sel_t                 wb_rollback_pipeline,
  input  logic                          in_valid,
  input  logic [THREAD_IDX_W-1:0]       in_thread_idx,
  input  logic [NUM_LANES-1:0]          in_mask,
  input  logic [NUM_LANES-1:0][31:0]    in_significand_le,
  input  logic [NUM_LANES-1:0][31:0]    in_significand_se,
  input  logic [NUM_LANES-1:0]          in_guard,
  input  logic [NUM_LANES-1:0]          in_round,
  input  logic [NUM_LANES-1:0]          in_sticky,
  input  logic [NUM_LANES-1:0]          in_logical_subtract,
  input  logic [NUM_LANES-1:0][7:0]     in_exponent,
  input  logic [NUM_LANES-1:0]          in_sign,
  input  logic [NUM_LANES-1:0]          in_result_inf,
  input  logic [NUM_LANES-1:0]          in_result_nan,
  output logic                          out_valid,
  output logic [THREAD_IDX_W-1:0]       out_thread_idx,
  output logic [NUM_LANES-1:0]          out_mask,
  output logic [NUM_LANES-1:0][31:0]    out_result
);

  // ---------------------------------------------------------------------
  // Valid tracking and rollback squash
  // ---------------------------------------------------------------------
  logic                        valid_a_q;
  logic                        valid_a_d;
  logic                        squash_a;
  logic                        valid_b_d;
  logic                        squash_b;
  logic [THREAD_IDX_W-1:0]     thread_a_q;
  logic [NUM_LANES-1:0]        mask_a_q;

  // A rollback only kills work belonging to the rolled-back thread when the
  // memory pipeline raised it; other pipelines' rollbacks do not affect us.
  assign squash_a  = wb_rollback_en && (wb_rollback_thread_idx == in_thread_idx)
                     && (wb_rollback_pipeline == PIPE_MEM);
  assign valid_a_d = in_valid && !squash_a;
  assign squash_b  = wb_rollback_en && (wb_rollback_thread_idx == thread_a_q)
                     && (wb_rollback_pipeline == PIPE_MEM);
  assign valid_b_d = valid_a_q && !squash_b;

  // ---------------------------------------------------------------------
  // Stage A: significand add/subtract and leading-zero count
  // ---------------------------------------------------------------------
  logic [NUM_LANES-1:0][27:0] raw_a_d;
  logic [NUM_LANES-1:0][4:0]  lzc_a_d;
  logic [NUM_LANES-1:0][27:0] raw_a_q;
  logic [NUM_LANES-1:0][4:0]  lzc_a_q;
  logic [NUM_LANES-1:0][7:0]  exp_a_q;
  logic [NUM_LANES-1:0]       sign_a_q;
  logic [NUM_LANES-1:0]       inf_a_q;
  logic [NUM_LANES-1:0]       nan_a_q;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane_a
    logic [27:0] op_l;
    logic [27:0] op_s;
    logic [27:0] raw;
    logic [4:0]  lzc;
    logic        unused_sig_hi;

    // Larger operand gets three zero extension bits so the smaller operand's
    // guard/round/sticky line up underneath it.
    assign op_l = {1'b0, in_significand_le[gi][23:0], 3'b000};
    assign op_s = {1'b0, in_significand_se[gi][23:0],
                   in_guard[gi], in_round[gi], in_sticky[gi]};
    assign raw  = in_logical_subtract[gi] ? (op_l - op_s) : (op_l + op_s);

    // Leading-zero count: scan upward so the highest set bit wins; 28 for zero.
    always_comb begin
      lzc = 5'd28;
      for (int i = 0; i < 28; i++) begin
        if (raw[i]) lzc = 5'(27 - i);
      end
    end

    assign raw_a_d[gi]   = raw;
    assign lzc_a_d[gi]   = lzc;
    // Only bits 23:0 of each significand carry information.
    assign unused_sig_hi = ^{in_significand_le[gi][31:24], in_significand_se[gi][31:24]};
  end

  // Stage A valid register; cleared asynchronously so in-flight work is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_a_q <= 1'b0;
    end else begin
      valid_a_q <= valid_a_d;
    end
  end

  // Stage A data registers load every cycle; valid alone qualifies them.
  always_ff @(posedge clk) begin
    raw_a_q    <= raw_a_d;
    lzc_a_q    <= lzc_a_d;
    exp_a_q    <= in_exponent;
    sign_a_q   <= in_sign;
    inf_a_q    <= in_result_inf;
    nan_a_q    <= in_result_nan;
    mask_a_q   <= in_mask;
    thread_a_q <= in_thread_idx;
  end

  // ---------------------------------------------------------------------
  // Stage B: normalize, round to nearest even, pack
  // ---------------------------------------------------------------------
  logic [NUM_LANES-1:0][31:0] result_b_d;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane_b
    logic [4:0]        lzc_m1;
    logic [27:0]       n_norm;
    logic [27:0]       n_rnd;
    logic signed [9:0] exp_norm;
    logic signed [9:0] exp_fin;
    logic [23:0]       mant;
    logic              rnd_up;
    logic [24:0]       mant_inc;
    logic              is_denorm;
    logic              raw_zero;
    logic [31:0]       res;
    logic              unused_b_bits;

    assign lzc_m1   = lzc_a_q[gi] - 5'd1;
    assign raw_zero = (raw_a_q[gi] == 28'd0);

    // Bring the hidden bit to position 26: a carry-out shifts right one place
    // (folding the dropped bit into sticky), otherwise shift left by lzc-1.
    always_comb begin
      n_norm   = '0;
      exp_norm = '0;
      if (raw_a_q[gi][27]) begin
        n_norm    = {1'b0, raw_a_q[gi][27:1]};
        n_norm[0] = raw_a_q[gi][1] | raw_a_q[gi][0];
        exp_norm  = $signed({2'b00, exp_a_q[gi]}) + 10'sd1;
      end else begin
        n_norm   = raw_a_q[gi] << lzc_m1;
        exp_norm = $signed({2'b00, exp_a_q[gi]}) - $signed({5'd0, lzc_m1});
      end
    end

`ifdef FP_DENORMAL_EN
    logic signed [9:0] dshift_s;
    logic [4:0]        dshift;
    logic [27:0]       dmask;

    // Underflowed results are denormalized: shift right (1 - exp) more places,
    // collecting everything shifted out into the sticky bit.
    always_comb begin
      is_denorm = (exp_norm <= 10'sd0) && !raw_zero;
      dshift_s  = 10'sd1 - exp_norm;
      dshift    = dshift_s[4:0];
      dmask     = ~(28'hFFFFFFF << dshift);
      n_rnd     = n_norm;
      if (is_denorm) begin
        if (dshift_s >= 10'sd28) begin
          n_rnd = {27'd0, |n_norm};
        end else begin
          n_rnd    = n_norm >> dshift;
          n_rnd[0] = n_rnd[0] | (|(n_norm & dmask));
        end
      end
    end
`else
    assign is_denorm = 1'b0;
    assign n_rnd     = n_norm;
`endif

    // Round to nearest, ties to even, on the 24-bit significand.
    assign mant     = n_rnd[26:3];
    assign rnd_up   = n_rnd[2] & ((|n_rnd[1:0]) | n_rnd[3]);
    assign mant_inc = {1'b0, mant} + {24'd0, rnd_up};

    // Final exponent accounts for a rounding carry; outputs picked by priority.
    always_comb begin
      exp_fin = exp_norm + (mant_inc[24] ? 10'sd1 : 10'sd0);
      res     = {sign_a_q[gi], exp_fin[7:0], mant_inc[22:0]};
      if (nan_a_q[gi]) begin
        res = 32'h7FFF_FFFF;
      end else if (inf_a_q[gi]) begin
        res = {sign_a_q[gi], 8'hFF, 23'd0};
      end else if (raw_zero) begin
        res = 32'h0000_0000;
      end else if (exp_fin >= 10'sd255) begin
        res = {sign_a_q[gi], 8'hFF, 23'd0};
      end else if (is_denorm) begin
        // A carry into bit 23 naturally becomes exponent field 1.
        res = {sign_a_q[gi], 7'd0, mant_inc[23:0]};
      end else if (exp_fin <= 10'sd0) begin
        res = {sign_a_q[gi], 31'd0};
      end
    end

    assign result_b_d[gi] = res;
    // Bit 27 is always clear after normalization; bit 23 only matters for subnormals.
    assign unused_b_bits  = ^{n_rnd[27], mant_inc[23]};
  end

  // ---------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------
  logic                        out_valid_q;
  logic [THREAD_IDX_W-1:0]     out_thread_q;
  logic [NUM_LANES-1:0]        out_mask_q;
  logic [NUM_LANES-1:0][31:0]  out_result_q;

  // Output stage register; all outputs clear asynchronously on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      out_thread_q <= '0;
      out_mask_q   <= '0;
      out_result_q <= '0;
    end else begin
      out_valid_q  <= valid_b_d;
      out_thread_q <= thread_a_q;
      out_mask_q   <= mask_a_q;
      out_result_q <= result_b_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_thread_idx = out_thread_q;
  assign out_mask       = out_mask_q;
  assign out_result     = out_result_q;

endmodule

// File: tb/tb_fp_add_normalize.sv
// Testbench for fp_add_normalize: directed cases plus randomized bundles,
// with a scoreboard queue fed at issue time and drained by a monitor.
module tb_fp_add_normalize;
  import fp_add_normalize_pkg::*;

  localparam int NL = 16;
  localparam int TW = 2;

  typedef logic [NL-1:0][31:0] res_vec_t;
  typedef struct {
    int          due;
    logic [TW-1:0] thr;
    logic [NL-1:0] mask;
    res_vec_t    res;
  } exp_t;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                wb_rollback_en;
  logic [TW-1:0]       wb_rollback_thread_idx;
  pipeline_sel_t       wb_rollback_pipeline;
  logic                in_valid;
  logic [TW-1:0]       in_thread_idx;
  logic [NL-1:0]       in_mask;
  logic [NL-1:0][31:0] in_significand_le;
  logic [NL-1:0][31:0] in_significand_se;
  logic [NL-1:0]       in_guard, in_round, in_sticky, in_logical_subtract;
  logic [NL-1:0][7:0]  in_exponent;
  logic [NL-1:0]       in_sign, in_result_inf, in_result_nan;
  logic                out_valid;
  logic [TW-1:0]       out_thread_idx;
  logic [NL-1:0]       out_mask;
  logic [NL-1:0][31:0] out_result;

  always #5 clk = ~clk;

  fp_add_normalize #(.NUM_LANES(NL), .THREAD_IDX_W(TW)) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .wb_rollback_en         (wb_rollback_en),
    .wb_rollback_thread_idx (wb_rollback_thread_idx),
    .wb_rollback_pipeline   (wb_rollback_pipeline),
    .in_valid               (in_valid),
    .in_thread_idx          (in_thread_idx),
    .in_mask                (in_mask),
    .in_significand_le      (in_significand_le),
    .in_significand_se      (in_significand_se),
    .in_guard               (in_guard),
    .in_round               (in_round),
    .in_sticky              (in_sticky),
    .in_logical_subtract    (in_logical_subtract),
    .in_exponent            (in_exponent),
    .in_sign                (in_sign),
    .in_result_inf          (in_result_inf),
    .in_result_nan          (in_result_nan),
    .out_valid              (out_valid),
    .out_thread_idx         (out_thread_idx),
    .out_mask               (out_mask),
    .out_result             (out_result)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  exp_t sb_q[$];
  exp_t pend;
  bit   pend_v = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %08h, expected %08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: exact integer sum, locate its leading one, round by comparing
  // the discarded remainder with one half ulp.
  function automatic logic [31:0] ref_lane(input logic [23:0] le, input logic [23:0] se,
                                           input logic g, input logic r, input logic s,
                                           input logic sub, input logic [7:0] ex,
                                           input logic sgn, input logic inf, input logic nan);
    longint opl, ops, raw, mant, rem, half;
    int     p, e, scale;
    bit     denorm;
    if (nan) return 32'h7FFFFFFF;
    if (inf) return {sgn, 8'hFF, 23'd0};
    opl = longint'(le) * 8;
    ops = longint'(se) * 8 + longint'(g) * 4 + longint'(r) * 2 + longint'(s);
    raw = sub ? (opl - ops) : (opl + ops);
    if (raw == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 40; i++) if ((raw >> i) != 0) p = i;
    e      = int'(ex) + p - 26;
    scale  = p - 23;
    denorm = 0;
`ifdef FP_DENORMAL_EN
    if (e <= 0) begin
      scale  = scale + 1 - e;
      denorm = 1;
    end
`endif
    if (scale <= 0) begin
      mant = raw << (-scale);
      rem  = 0;
      half = 1;
    end else begin
      mant = raw >> scale;
      rem  = raw - (mant << scale);
      half = longint'(1) << (scale - 1);
    end
    if (rem > half || (rem == half && mant[0])) mant = mant + 1;
    if (denorm) return {sgn, 31'(mant)};
    if (mant == (longint'(1) << 24)) begin
      mant = mant >> 1;
      e    = e + 1;
    end
    if (e >= 255) return {sgn, 8'hFF, 23'd0};
    if (e <= 0) return {sgn, 31'd0};
    return {sgn, 8'(e), 23'(mant)};
  endfunction

  function automatic res_vec_t model_vec();
    res_vec_t v;
    for (int l = 0; l < NL; l++)
      v[l] = ref_lane(in_significand_le[l][23:0], in_significand_se[l][23:0], in_guard[l],
                      in_round[l], in_sticky[l], in_logical_subtract[l], in_exponent[l],
                      in_sign[l], in_result_inf[l], in_result_nan[l]);
    return v;
  endfunction

  function automatic res_vec_t fill(input logic [31:0] x);
    res_vec_t v;
    for (int l = 0; l < NL; l++) v[l] = x;
    return v;
  endfunction

  // Applies the squash rules for this cycle's inputs: the bundle sitting in
  // stage A is delivered unless rolled back now; the new bundle enters stage A
  // unless rolled back now.
  task automatic commit(input res_vec_t res);
    bit sq_a, sq_b;
    sq_b = wb_rollback_en && (wb_rollback_thread_idx == pend.thr) &&
           (wb_rollback_pipeline == PIPE_MEM);
    if (pend_v && !sq_b) sb_q.push_back(pend);
    sq_a = wb_rollback_en && (wb_rollback_thread_idx == in_thread_idx) &&
           (wb_rollback_pipeline == PIPE_MEM);
    pend_v    = in_valid && !sq_a;
    pend.due  = cyc + 2;
    pend.thr  = in_thread_idx;
    pend.mask = in_mask;
    pend.res  = res;
  endtask

  task automatic set_lanes_dir(input logic [23:0] le, input logic [23:0] se, input logic g,
                               input logic r, input logic s, input logic sub,
                               input logic [7:0] ex, input logic sgn, input logic nan);
    for (int l = 0; l < NL; l++) begin
      in_significand_le[l]   = {8'd0, le};
      in_significand_se[l]   = {8'd0, se};
      in_guard[l]            = g;
      in_round[l]            = r;
      in_sticky[l]           = s;
      in_logical_subtract[l] = sub;
      in_exponent[l]         = ex;
      in_sign[l]             = sgn;
      in_result_inf[l]       = 1'b0;
      in_result_nan[l]       = nan;
    end
  endtask

  task automatic set_lanes_rand();
    logic [23:0] le, se;
    for (int l = 0; l < NL; l++) begin
      le = 24'h800000 | 24'($urandom_range(0, 24'h7FFFFF));
      in_logical_subtract[l] = 1'($urandom);
      in_guard[l]  = 1'($urandom);
      in_round[l]  = 1'($urandom);
      in_sticky[l] = 1'($urandom);
      if (in_logical_subtract[l]) begin
        case ($urandom_range(0, 3))
          0:       se = le - 24'($urandom_range(1, 64));
          1: begin se = le; in_guard[l] = 0; in_round[l] = 0; in_sticky[l] = 0; end
          default: se = 24'($urandom_range(0, int'(le) - 1));
        endcase
      end else begin
        se = 24'($urandom_range(0, int'(le)));
      end
      in_significand_le[l] = {8'($urandom), le};
      in_significand_se[l] = {8'($urandom), se};
      in_exponent[l]   = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 30))
                                                     : 8'($urandom_range(1, 254));
      in_sign[l]       = 1'($urandom);
      in_result_inf[l] = ($urandom_range(0, 31) == 0);
      in_result_nan[l] = ($urandom_range(0, 31) == 0);
    end
  endtask

  task automatic dir(input logic [23:0] le, input logic [23:0] se, input logic g, input logic r,
                     input logic s, input logic sub, input logic [7:0] ex, input logic nan,
                     input logic [TW-1:0] thr, input logic rb_en, input logic [TW-1:0] rb_thr,
                     input pipeline_sel_t rb_pipe, input logic [31:0] expv);
    set_lanes_dir(le, se, g, r, s, sub, ex, 1'b0, nan);
    in_valid               = 1'b1;
    in_thread_idx          = thr;
    in_mask                = NL'($urandom);
    wb_rollback_en         = rb_en;
    wb_rollback_thread_idx = rb_thr;
    wb_rollback_pipeline   = rb_pipe;
    commit(fill(expv));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      in_valid       = 1'b0;
      wb_rollback_en = 1'b0;
      commit(fill(32'h0));
      @(negedge clk);
    end
  endtask

  // Monitor: every valid output must match the oldest expectation, on time.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_valid: got out_valid=1 thread %0d, expected no result (cycle %0d)",
                   out_thread_idx, cyc);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          $display("result cycle %0d thread %0d mask %04h lane0 %08h", cyc, out_thread_idx,
                   out_mask, out_result[0]);
          chk("latency_cycle", 32'(cyc), 32'(e.due));
          chk("out_thread_idx", 32'(out_thread_idx), 32'(e.thr));
          chk("out_mask", 32'(out_mask), 32'(e.mask));
          for (int l = 0; l < NL; l++) chk($sformatf("lane%0d_result", l), out_result[l], e.res[l]);
        end
      end
    end
  end

  initial begin
    logic [31:0] uf_exp;
    in_valid = 0; in_thread_idx = 0; in_mask = 0;
    wb_rollback_en = 0; wb_rollback_thread_idx = 0; wb_rollback_pipeline = PIPE_INT_ARITH;
    set_lanes_dir(24'h0, 24'h0, 0, 0, 0, 0, 8'd0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_out_thread", 32'(out_thread_idx), 32'h0);
    chk("reset_out_mask", 32'(out_mask), 32'h0);
    chk("reset_out_result_or", 32'(|out_result), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(2);

    // Arithmetic corner cases.
    dir(24'h800000, 24'h800000, 0, 0, 0, 0, 8'd127, 0, 2'd0, 0, 2'd0, PIPE_MEM, 32'h40000000);
    idle(2);
    dir(24'h800000, 24'h800000, 0, 0, 0, 1, 8'd127, 0, 2'd1, 0, 2'd0, PIPE_MEM, 32'h00000000);
    dir(24'h800000, 24'h600000, 0, 0, 0, 1, 8'd127, 0, 2'd2, 0, 2'd0, PIPE_MEM, 32'h3E800000);
    dir(24'h800000, 24'h000000, 1, 0, 0, 0, 8'd127, 0, 2'd3, 0, 2'd0, PIPE_MEM, 32'h3F800000);
    dir(24'h800001, 24'h000000, 1, 0, 0, 0, 8'd127, 0, 2'd0, 0, 2'd0, PIPE_MEM, 32'h3F800002);
    dir(24'hC00000, 24'hC00000, 0, 0, 0, 0, 8'd254, 0, 2'd1, 0, 2'd0, PIPE_MEM, 32'h7F800000);
    dir(24'h812345, 24'h234567, 1, 1, 0, 0, 8'd100, 1, 2'd2, 0, 2'd0, PIPE_MEM, 32'h7FFFFFFF);
`ifdef FP_DENORMAL_EN
    uf_exp = 32'h00400000;
`else
    uf_exp = 32'h00000000;
`endif
    dir(24'h800000, 24'h400000, 0, 0, 0, 1, 8'd1, 0, 2'd3, 0, 2'd0, PIPE_MEM, uf_exp);
    idle(3);

    // Rollback: stage A hit, wrong thread, wrong pipeline, stage B hit.
    dir(24'h800000, 24'h800000, 0, 0, 0, 0, 8'd127, 0, 2'd2, 1, 2'd2, PIPE_MEM, 32'h40000000);
    idle(3);
    dir(24'h800000, 24'h800000, 0, 0, 0, 0, 8'd127, 0, 2'd2, 1, 2'd1, PIPE_MEM, 32'h40000000);
    dir(24'h800000, 24'h600000, 0, 0, 0, 1, 8'd127, 0, 2'd2, 1, 2'd2, PIPE_FP_ARITH, 32'h3E800000);
    idle(3);
    dir(24'h800000, 24'h800000, 0, 0, 0, 0, 8'd127, 0, 2'd2, 0, 2'd0, PIPE_MEM, 32'h40000000);
    in_valid = 1'b0;
    wb_rollback_en = 1'b1; wb_rollback_thread_idx = 2'd2; wb_rollback_pipeline = PIPE_MEM;
    commit(fill(32'h0));
    @(negedge clk);
    idle(3);

    // Randomized traffic with random rollbacks.
    for (int t = 0; t < 1500; t++) begin
      set_lanes_rand();
      in_valid               = ($urandom_range(0, 3) != 0);
      in_thread_idx          = TW'($urandom);
      in_mask                = NL'($urandom);
      wb_rollback_en         = ($urandom_range(0, 3) == 0);
      wb_rollback_thread_idx = TW'($urandom);
      wb_rollback_pipeline   = pipeline_sel_t'($urandom_range(0, 3));
      commit(model_vec());
      @(negedge clk);
    end
    idle(4);

    // Reset with one bundle on the outputs and another in stage A.
    dir(24'h800000, 24'h800000, 0, 0, 0, 0, 8'd127, 0, 2'd1, 0, 2'd0, PIPE_MEM, 32'h40000000);
    dir(24'h800000, 24'h600000, 0, 0, 0, 1, 8'd127, 0, 2'd1, 0, 2'd0, PIPE_MEM, 32'h3E800000);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    pend_v   = 0;
    #1;
    chk("async_reset_out_valid", 32'(out_valid), 32'h0);
    chk("async_reset_out_result_or", 32'(|out_result), 32'h0);
    @(posedge clk);
    #1;
    chk("inflight_reset_out_valid", 32'(out_valid), 32'h0);
    chk("inflight_reset_out_result_or", 32'(|out_result), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(4);

    chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
